// File: rtl/brick_field.sv
// Brick-breaker playfield: 64-brick map, paddle position and a 3-cycle hit scan per ball_tick.
// Latency: data is combinational from state; a scan retires 4 edges after ball_tick.
// Backpressure: none; ball_tick is dropped while busy, move_tick is always accepted.
module brick_field (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   Ball_rowIndex,
    input  logic [3:0]   Ball_colIndex,
    input  logic [1:0]   Ball_direction,
    input  logic         ball_tick,
    input  logic         move_tick,
    input  logic         btn_left,
    input  logic         btn_right,
    output logic [191:0] data,
    output logic [7:0]   score,
    output logic [6:0]   bricks_left,
    output logic         busy,
    output logic         level_clear
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHK_V = 2'd1,
        CHK_H = 2'd2,
        CHK_D = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] bricks;      // rows 1..4 only; bit (row-1)*16+col
    logic [3:0]  paddle_col;
    logic [3:0]  row_q;
    logic [3:0]  col_q;
    logic [1:0]  dir_q;
    logic        hit_q;       // a brick was already cleared in this scan

    logic signed [5:0] d_row;
    logic signed [5:0] d_col;
    logic signed [5:0] cand_row;
    logic signed [5:0] cand_col;
    logic              cand_in_bricks;
    logic [1:0]        row_off;
    logic [5:0]        brick_idx;
    logic              hit;

    // Candidate cell for the current check; signed so off-field cells are detectable.
    always_comb begin
        d_row    = dir_q[1] ? 6'sd1 : -6'sd1;
        d_col    = dir_q[0] ? 6'sd1 : -6'sd1;
        cand_row = $signed({2'b00, row_q});
        cand_col = $signed({2'b00, col_q});
        if (state == CHK_V || state == CHK_D) begin
            cand_row = cand_row + d_row;
        end
        if (state == CHK_H || state == CHK_D) begin
            cand_col = cand_col + d_col;
        end
        cand_in_bricks = (cand_row >= 6'sd1) && (cand_row <= 6'sd4) &&
                         (cand_col >= 6'sd0) && (cand_col <= 6'sd15);
        row_off   = 2'(cand_row[2:0] - 3'd1);
        brick_idx = {row_off, cand_col[3:0]};
        hit       = (state != IDLE) && cand_in_bricks && bricks[brick_idx] &&
                    (bricks_left != 7'd0) && !((state == CHK_D) && hit_q);
    end

    always_comb begin
        data            = '0;
        data[79:16]     = bricks;
        data[175:160]   = 16'(16'h000F << paddle_col);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            paddle_col <= 4'd6;
        end else if (move_tick && (btn_left != btn_right)) begin
            if (btn_left && paddle_col != 4'd12) begin
                paddle_col <= paddle_col + 4'd1;
            end else if (btn_right && paddle_col != 4'd0) begin
                paddle_col <= paddle_col - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bricks      <= '1;
            row_q       <= '0;
            col_q       <= '0;
            dir_q       <= '0;
            hit_q       <= 1'b0;
            score       <= '0;
            bricks_left <= 7'd64;
            level_clear <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ball_tick) begin
                        row_q <= Ball_rowIndex;
                        col_q <= Ball_colIndex;
                        dir_q <= Ball_direction;
                        hit_q <= 1'b0;
                        state <= CHK_V;
                    end
                end
                CHK_V:   state <= CHK_H;
                CHK_H:   state <= CHK_D;
                default: state <= IDLE;
            endcase
            if (hit) begin
                bricks[brick_idx] <= 1'b0;
                hit_q             <= 1'b1;
                score             <= score + 8'd1;
                bricks_left       <= bricks_left - 7'd1;
                if (bricks_left == 7'd1) begin
                    level_clear <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field with hand-computed expectations.
module tb_brick_field;

    logic         clock;
    logic         reset;
    logic [3:0]   Ball_rowIndex;
    logic [3:0]   Ball_colIndex;
    logic [1:0]   Ball_direction;
    logic         ball_tick;
    logic         move_tick;
    logic         btn_left;
    logic         btn_right;
    logic [191:0] data;
    logic [7:0]   score;
    logic [6:0]   bricks_left;
    logic         busy;
    logic         level_clear;

    int errors = 0;
    int checks = 0;

    logic [191:0] exp_br;      // expected brick bits only
    logic [3:0]   exp_pc;      // expected paddle column
    int           exp_score;

    brick_field dut (
        .clock          (clock),
        .reset          (reset),
        .Ball_rowIndex  (Ball_rowIndex),
        .Ball_colIndex  (Ball_colIndex),
        .Ball_direction (Ball_direction),
        .ball_tick      (ball_tick),
        .move_tick      (move_tick),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .data           (data),
        .score          (score),
        .bricks_left    (bricks_left),
        .busy           (busy),
        .level_clear    (level_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] exp_data();
        logic [191:0] p;
        p = 192'hF;
        return exp_br | (p << (160 + int'(exp_pc)));
    endfunction

    task automatic tick(input int r, input int c, input logic [1:0] d);
        Ball_rowIndex  = 4'(r);
        Ball_colIndex  = 4'(c);
        Ball_direction = d;
        ball_tick      = 1'b1;
        @(negedge clock);
        ball_tick      = 1'b0;
    endtask

    task automatic move(input logic l, input logic r, input int n);
        btn_left  = l;
        btn_right = r;
        for (int i = 0; i < n; i++) begin
            move_tick = 1'b1;
            @(negedge clock);
            move_tick = 1'b0;
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        Ball_rowIndex = '0; Ball_colIndex = '0; Ball_direction = '0;
        ball_tick = 1'b0; move_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        exp_br = '0;
        for (int i = 16; i < 80; i++) exp_br[i] = 1'b1;
        exp_pc = 4'd6;
        exp_score = 0;
        wait_edges(2);
        reset = 1'b1;

        // Reset state
        check("rst_data", data, exp_data());
        check("rst_paddle_bits", 192'(data[169:166]), 192'hF);
        check("rst_score", 192'(score), 192'd0);
        check("rst_left", 192'(bricks_left), 192'd64);
        check("rst_busy", 192'(busy), 192'd0);
        check("rst_lvl", 192'(level_clear), 192'd0);

        // Ball (5,7) up-right: V clears (4,7)=bit 71
        tick(5, 7, 2'b00);
        check("s2_busy1", 192'(busy), 192'd1);
        @(negedge clock);
        check("s2_bit71", 192'(data[71]), 192'd0);
        check("s2_busy2", 192'(busy), 192'd1);
        @(negedge clock);
        check("s2_busy3", 192'(busy), 192'd1);
        @(negedge clock);
        check("s2_idle", 192'(busy), 192'd0);
        exp_br[71] = 1'b0;
        check("s2_data", data, exp_data());
        check("s2_score", 192'(score), 192'd1);
        check("s2_left", 192'(bricks_left), 192'd63);

        // Ball (5,0) up-right twice: first clears (4,0)=bit 64, second finds nothing
        tick(5, 0, 2'b00); wait_edges(3);
        exp_br[64] = 1'b0;
        check("s3_pre_data", data, exp_data());
        tick(5, 0, 2'b00); wait_edges(3);
        check("s3_data", data, exp_data());
        check("s3_score", 192'(score), 192'd2);

        // Pre-clear (4,8), then up-left from (5,8): D clears (4,9)=bit 73
        tick(5, 8, 2'b00); wait_edges(3);
        exp_br[72] = 1'b0;
        tick(5, 8, 2'b01);
        tick(2, 2, 2'b00);            // arrives while busy; must be dropped
        wait_edges(2);
        check("s4_busy_end", 192'(busy), 192'd0);
        exp_br[73] = 1'b0;
        check("s4_data", data, exp_data());
        check("s4_score", 192'(score), 192'd4);
        check("s4_left", 192'(bricks_left), 192'd60);

        // Paddle saturation and button conflicts
        move(1'b1, 1'b0, 3);
        check("pad_col9", 192'(data[175:160]), 192'h1E00);
        move(1'b1, 1'b0, 7);
        check("pad_sat12", 192'(data[175:160]), 192'hF000);
        move(1'b1, 1'b1, 2);
        check("pad_both", 192'(data[175:160]), 192'hF000);
        move(1'b0, 1'b0, 2);
        check("pad_none", 192'(data[175:160]), 192'hF000);
        move(1'b0, 1'b1, 1);
        check("pad_right1", 192'(data[175:160]), 192'h7800);
        move(1'b0, 1'b1, 15);
        check("pad_sat0", 192'(data[175:160]), 192'h000F);
        exp_pc = 4'd0;

        // Sweep down-right from the row above each brick; every scan clears at most its V cell
        exp_score = 4;
        for (int k = 1; k <= 4; k++) begin
            for (int c = 0; c < 16; c++) begin
                if (!(k == 4 && c == 15)) begin
                    tick(k - 1, c, 2'b10); wait_edges(3);
                    if (exp_br[k*16 + c]) exp_score++;
                    exp_br[k*16 + c] = 1'b0;
                end
            end
        end
        check("sw_data", data, exp_data());
        check("sw_score", 192'(score), 192'(exp_score));
        check("sw_left1", 192'(bricks_left), 192'd1);
        check("sw_lvl0", 192'(level_clear), 192'd0);

        // Last brick, with a paddle move in the same cycle as ball_tick
        Ball_rowIndex = 4'd3; Ball_colIndex = 4'd15; Ball_direction = 2'b10;
        ball_tick = 1'b1; move_tick = 1'b1; btn_left = 1'b1;
        @(negedge clock);
        ball_tick = 1'b0; move_tick = 1'b0; btn_left = 1'b0;
        exp_pc = 4'd1;
        check("last_busy", 192'(busy), 192'd1);
        check("last_pad", 192'(data[175:160]), 192'h001E);
        @(negedge clock);
        check("last_lvl", 192'(level_clear), 192'd1);
        check("last_left", 192'(bricks_left), 192'd0);
        check("last_score", 192'(score), 192'd64);
        wait_edges(2);
        exp_br = '0;
        check("clear_data", data, exp_data());

        // Ticks after clear still scan but change nothing
        tick(5, 5, 2'b00);
        check("post_busy", 192'(busy), 192'd1);
        wait_edges(3);
        check("post_score", 192'(score), 192'd64);
        check("post_lvl", 192'(level_clear), 192'd1);

        // Reset in the middle of a scan
        tick(3, 3, 2'b10);
        @(negedge clock);
        check("mid_busy", 192'(busy), 192'd1);
        reset = 1'b0;
        #1;
        for (int i = 16; i < 80; i++) exp_br[i] = 1'b1;
        exp_pc = 4'd6;
        check("mr_busy", 192'(busy), 192'd0);
        check("mr_data", data, exp_data());
        check("mr_score", 192'(score), 192'd0);
        check("mr_left", 192'(bricks_left), 192'd64);
        check("mr_lvl", 192'(level_clear), 192'd0);
        @(negedge clock);
        reset = 1'b1;

        // Normal operation after reset
        tick(5, 7, 2'b00); wait_edges(3);
        exp_br[71] = 1'b0;
        check("after_data", data, exp_data());
        check("after_score", 192'(score), 192'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brick_field.md
BRICK_FIELD -- requirements
Module: brick_field

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, with ports declared in this order:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- Ball_rowIndex  in  4  ball row, 0..11.
- Ball_colIndex  in  4  ball column, 0..15.
- Ball_direction  in  2  00 UP_RIGHT (row-1, col-1); 01 UP_LEFT (row-1, col+1); 10 DOWN_RIGHT (row+1, col-1); 11 DOWN_LEFT (row+1, col+1).
- ball_tick  in  1  one-cycle pulse: ball position/direction valid, resolve hits.
- move_tick  in  1  one-cycle pulse: paddle move opportunity.
- btn_left  in  1  level; request paddle toward higher column.
- btn_right  in  1  level; request paddle toward lower column.
- data  out  192  occupancy map; bit row*16+col = brick OR paddle cell.
- score  out  8  bricks destroyed since reset.
- bricks_left  out  7  remaining bricks.
- busy  out  1  high while the hit scan is in progress.
- level_clear  out  1  sticky; high once bricks_left reaches 0.

Function
REQ-002 The block SHALL hold a 12x16 registered brick map; only rows 1..4 ever hold bricks (64 cells).
REQ-003 The paddle SHALL occupy row 10, columns paddle_col..paddle_col+3, with paddle_col (4 bits) in range 0..12.
REQ-004 data SHALL be the combinational OR of the brick map and the paddle mask, with no added latency from the registers.
REQ-005 On move_tick, the paddle SHALL move as follows:
- btn_left only: paddle_col+1, saturating at 12.
- btn_right only: paddle_col-1, saturating at 0.
- Both or neither: no change.
REQ-006 Paddle motion SHALL be independent of the hit FSM; move_tick and ball_tick in the same cycle SHALL both take effect.
REQ-007 The hit FSM SHALL have four states:
- IDLE: on ball_tick, latch row, column and direction, then go to CHK_V.
- CHK_V: go to CHK_H.
- CHK_H: go to CHK_D.
- CHK_D: go to IDLE.
REQ-008 busy SHALL be high exactly when the FSM is not in IDLE; a ball_tick arriving while busy SHALL be ignored.
REQ-009 The checked cells SHALL be taken from the latched values (r, c) and direction offsets (dr, dc):
- CHK_V checks (r+dr, c).
- CHK_H checks (r, c+dc).
- CHK_D checks (r+dr, c+dc).
REQ-010 A candidate cell outside rows 0..11 or columns 0..15 (for example row 0 going up, column 15 going left) SHALL be skipped, with no wrap-around.
REQ-011 A candidate cell in rows 1..4 holding a brick SHALL be cleared at the end of that check cycle, with score incremented by 1 and bricks_left decremented by 1 in the same edge.
REQ-012 Cells outside rows 1..4, including paddle cells, SHALL never be cleared.
REQ-013 CHK_D SHALL clear its cell only if neither CHK_V nor CHK_H cleared a brick during the current scan.
REQ-014 Therefore 0..2 bricks SHALL be cleared per scan; the scan always spans 3 cycles (latency ball_tick -> idle = 4 edges).
REQ-015 score SHALL be 8-bit and cannot exceed 64; bricks_left SHALL never decrement below 0.
REQ-016 level_clear SHALL be set on the edge where bricks_left becomes 0 and SHALL hold until reset.
REQ-017 Once level_clear is set, further ball_tick pulses SHALL still run the FSM but SHALL change nothing.

Reset
REQ-018 When reset is low, the block SHALL immediately force the following, regardless of FSM state (a scan in flight is aborted):
- FSM to IDLE, busy=0.
- Brick map rows 1..4 all 1s, all other rows 0.
- paddle_col=6, i.e. data bits 166..169 set.
- score=0, bricks_left=64, level_clear=0.
REQ-019 Latched ball values SHALL reset to row 0, column 0, direction 00; they are unobservable and are used only on the next ball_tick.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset release: data has bits 16..79 and 166..169 set, all other bits 0; score=0; bricks_left=64; busy=0.
- Ball (5,7) dir 00 + ball_tick: busy high 3 cycles; bit 71 (4,7) cleared after CHK_V; H cell (5,6) empty; D skipped; score=1; bricks_left=63.
- Ball (5,0) dir 00, (4,0) pre-cleared, (5,-1) out of range: D clears (4,-1)? No -- out of range. Expected: no change and score unchanged.
- Ball (5,8) dir 01, (4,8) pre-cleared: D clears bit 73 (4,9); score +1; a second ball_tick during busy is ignored.
- move_tick with btn_left held 10 pulses: paddle_col saturates at 12, bits 172..175 set; both buttons held -> no move.
- Clear all 64 bricks via scans: level_clear rises on the edge bricks_left hits 0; score=64; assert reset mid-scan -> full map restored, busy=0.
